riscv_soc: RTL and testbench

Minimal RV32I system-on-chip for running self-checking ISA test images.
- Contains a 3-stage pipelined integer core (IF, ID, EX), an instruction ROM and a byte-lane data RAM.
- No external I/O besides clock and reset. Results are observed through the core's register file.
- Test convention: x26=1 means done, x27=1 means pass, x3 holds the test number.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/dual_ram.sv | 25 ++
 rtl/riscv_soc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_riscv_soc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_soc core: RV32I opcode and funct codes,
// load/store size encodings, the ALU operation enum and reset constants.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store size (funct3)
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

endpackage

// File: rtl/dual_ram.sv
// Simple two-port RAM: one synchronous write port with enable, one
// synchronous read port (data valid one cycle after raddr).
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module dual_ram #(
  parameter int W  = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // NOTE: storage arrays get no reset so they map onto block RAM; contents
  // are loaded externally and must survive a core reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/riscv_soc.sv
// Minimal RV32I SoC: 3-stage core (IF, ID, EX), instruction ROM and a
// four-lane byte data RAM. Results are observed through register file rf.
// Ports: clk (rising edge); rstn (asynchronous, active-high reset).
module riscv_soc import riscv_pkg::*; #(
  parameter int          MEM_AW   = 18,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input logic clk,
  input logic rstn
);

  logic [31:0] rf [32];

  // ---------------- IF ----------------
  logic [31:0] pc, id_pc, fetch_addr, rom_q, target;
  logic        id_valid, stall, take;

  // A stall re-reads the instruction already in ID so the ROM output holds.
  assign fetch_addr = stall ? id_pc : pc;

  dual_ram #(.W(32), .AW(MEM_AW)) u_rom (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(fetch_addr[MEM_AW+1:2]), .rdata(rom_q)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pc       <= RESET_PC;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (take) begin
      pc       <= target;
      id_valid <= 1'b0;  // squash the instruction being fetched
    end else if (!stall) begin
      pc       <= pc + 32'd4;
      id_pc    <= pc;
      id_valid <= 1'b1;
    end
  end

  // ---------------- ID ----------------
  logic [31:0] id_instr, id_imm, id_a, id_b, ex_result, ld_data;
  logic [6:0]  id_op;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ld_rd;
  logic        id_known, uses_rs1, uses_rs2, ex_wen, ld_wen, ex_is_load;
  alu_op_e     id_alu;

  assign id_known = rom_q[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                    OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
  // FENCE, SYSTEM and undefined opcodes degrade to NOP here.
  assign id_instr = (id_valid && id_known) ? rom_q : NOP;
  assign id_op    = id_instr[6:0];
  assign id_rs1   = id_instr[19:15];
  assign id_rs2   = id_instr[24:20];
  assign uses_rs1 = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2 = id_op inside {OP_BRANCH, OP_STORE, OP_OP};

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    id_imm = {{20{id_instr[31]}}, id_instr[31:20]};
    case (id_op)
      OP_STORE:         id_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      OP_BRANCH:        id_imm = {{20{id_instr[31]}}, id_instr[7], id_instr[30:25],
                                  id_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: id_imm = {id_instr[31:12], 12'b0};
      OP_JAL:           id_imm = {{12{id_instr[31]}}, id_instr[19:12], id_instr[20],
                                  id_instr[30:21], 1'b0};
      default: ;
    endcase
  end

  always_comb begin
    id_alu = ALU_ADD;
    if (id_op == OP_LUI) begin
      id_alu = ALU_PASS_B;
    end else if (id_op == OP_OP || id_op == OP_IMM) begin
      case (id_instr[14:12])
        F3_ADD:  id_alu = (id_op == OP_OP && id_instr[30]) ? ALU_SUB : ALU_ADD;
        F3_SLL:  id_alu = ALU_SLL;
        F3_SLT:  id_alu = ALU_SLT;
        F3_SLTU: id_alu = ALU_SLTU;
        F3_XOR:  id_alu = ALU_XOR;
        F3_SR:   id_alu = id_instr[30] ? ALU_SRA : ALU_SRL;
        F3_OR:   id_alu = ALU_OR;
        F3_AND:  id_alu = ALU_AND;
      endcase
    end
  end

  // Operand read: EX result (youngest) beats load writeback beats the array.
  always_comb begin
    id_a = rf[id_rs1];
    if (ld_wen && ld_rd == id_rs1) id_a = ld_data;
    if (ex_wen && ex_rd == id_rs1) id_a = ex_result;
    if (id_rs1 == 5'd0) id_a = '0;
    id_b = rf[id_rs2];
    if (ld_wen && ld_rd == id_rs2) id_b = ld_data;
    if (ex_wen && ex_rd == id_rs2) id_b = ex_result;
    if (id_rs2 == 5'd0) id_b = '0;
  end

  // Load data only exists next cycle, so a consumer waits one cycle in ID.
  assign stall = ex_is_load && ex_rd != 5'd0 && !take &&
                 ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd));

  // ---------------- ID/EX ----------------
  logic [31:0] ex_instr, ex_pc, ex_a, ex_b, ex_imm;
  alu_op_e     ex_alu;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn || take || stall) begin
      ex_instr <= NOP;
      ex_pc    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_alu   <= ALU_ADD;
    end else begin
      ex_instr <= id_instr;
      ex_pc    <= id_pc;
      ex_a     <= id_a;
      ex_b     <= id_b;
      ex_imm   <= id_imm;
      ex_alu   <= id_alu;
    end
  end

  // ---------------- EX ----------------
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3, ld_f3;
  logic [31:0] alu_a, alu_b, alu_y, ex_addr, store_word, ram_q;
  logic [4:0]  sh;
  logic [3:0]  ram_we;
  logic        cond;
  logic [1:0]  ld_off;
  logic        ld_pending;

  assign ex_op      = ex_instr[6:0];
  assign ex_f3      = ex_instr[14:12];
  assign ex_rd      = ex_instr[11:7];
  assign ex_is_load = ex_op == OP_LOAD;
  assign alu_a      = (ex_op == OP_AUIPC) ? ex_pc : ex_a;
  assign alu_b      = (ex_op == OP_OP) ? ex_b : ex_imm;
  assign sh         = alu_b[4:0];
  assign ex_addr    = ex_a + ex_imm;

  always_comb begin
    alu_y = alu_a + alu_b;
    case (ex_alu)
      ALU_SUB:    alu_y = alu_a - alu_b;
      ALU_SLL:    alu_y = alu_a << sh;
      ALU_SLT:    alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:    alu_y = alu_a ^ alu_b;
      ALU_SRL:    alu_y = alu_a >> sh;
      ALU_SRA:    alu_y = $signed(alu_a) >>> sh;
      ALU_OR:     alu_y = alu_a | alu_b;
      ALU_AND:    alu_y = alu_a & alu_b;
      ALU_PASS_B: alu_y = alu_b;
      default: ;
    endcase
  end

  always_comb begin
    case (ex_f3)
      F3_BEQ:  cond = ex_a == ex_b;
      F3_BNE:  cond = ex_a != ex_b;
      F3_BLT:  cond = $signed(ex_a) < $signed(ex_b);
      F3_BGE:  cond = $signed(ex_a) >= $signed(ex_b);
      F3_BLTU: cond = ex_a < ex_b;
      F3_BGEU: cond = ex_a >= ex_b;
      default: cond = 1'b0;
    endcase
  end

  assign take   = ex_op == OP_JAL || ex_op == OP_JALR || (ex_op == OP_BRANCH && cond);
  assign target = (ex_op == OP_JALR) ? (ex_addr & ~32'd1) : ex_pc + ex_imm;
  assign ex_result = (ex_op == OP_JAL || ex_op == OP_JALR) ? ex_pc + 32'd4 : alu_y;
  assign ex_wen = ex_rd != 5'd0 &&
                  (ex_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP});

  // Store data is replicated; lane enables pick the bytes actually written.
  always_comb begin
    ram_we     = 4'b0000;
    store_word = ex_b;
    if (ex_op == OP_STORE) begin
      case (ex_f3)
        SZ_B: begin
          ram_we     = 4'b0001 << ex_addr[1:0];
          store_word = {4{ex_b[7:0]}};
        end
        SZ_H: begin
          ram_we     = ex_addr[1] ? 4'b1100 : 4'b0011;
          store_word = {2{ex_b[15:0]}};
        end
        default: ram_we = 4'b1111;
      endcase
    end
  end

  dual_ram #(.W(8), .AW(MEM_AW)) u_ram0 (.clk(clk), .we(ram_we[0]),
    .waddr(ex_addr[MEM_AW+1:2]), .wdata(store_word[7:0]),
    .raddr(ex_addr[MEM_AW+1:2]), .rdata(ram_q[7:0]));
  dual_ram #(.W(8), .AW(MEM_AW)) u_ram1 (.clk(clk), .we(ram_we[1]),
    .waddr(ex_addr[MEM_AW+1:2]), .wdata(store_word[15:8]),
    .raddr(ex_addr[MEM_AW+1:2]), .rdata(ram_q[15:8]));
  dual_ram #(.W(8), .AW(MEM_AW)) u_ram2 (.clk(clk), .we(ram_we[2]),
    .waddr(ex_addr[MEM_AW+1:2]), .wdata(store_word[23:16]),
    .raddr(ex_addr[MEM_AW+1:2]), .rdata(ram_q[23:16]));
  dual_ram #(.W(8), .AW(MEM_AW)) u_ram3 (.clk(clk), .we(ram_we[3]),
    .waddr(ex_addr[MEM_AW+1:2]), .wdata(store_word[31:24]),
    .raddr(ex_addr[MEM_AW+1:2]), .rdata(ram_q[31:24]));

  // ---------------- Load writeback (cycle after EX) ----------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ld_pending <= 1'b0;
      ld_rd      <= '0;
      ld_f3      <= '0;
      ld_off     <= '0;
    end else begin
      ld_pending <= ex_is_load;
      ld_rd      <= ex_rd;
      ld_f3      <= ex_f3;
      ld_off     <= ex_addr[1:0];
    end
  end

  logic [31:0] ld_shift;
  logic [15:0] ld_half;
  assign ld_shift = ram_q >> {ld_off, 3'b000};
  assign ld_half  = ld_off[1] ? ram_q[31:16] : ram_q[15:0];
  assign ld_wen   = ld_pending && ld_rd != 5'd0;

  always_comb begin
    case (ld_f3)
      SZ_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      SZ_BU:   ld_data = {24'b0, ld_shift[7:0]};
      SZ_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = ram_q;
    endcase
  end

  // Both writes can land in one cycle; the EX write is younger and wins.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (ld_wen) rf[ld_rd] <= ld_data;
      if (ex_wen) rf[ex_rd] <= ex_result;
    end
  end

  logic unused;
  assign unused = ^{ex_instr[31:15], ex_addr[31:MEM_AW+2], fetch_addr[31:MEM_AW+2],
                    fetch_addr[1:0], id_instr[31], id_instr[29:25], rf[0], ex_f3 == SZ_W};

endmodule

// File: tb/tb_riscv_soc.sv
// Self-checking bench for riscv_soc: directed programs with hand-computed
// results; a scoreboard queue is drained by a monitor once x26 becomes 1.
module tb_riscv_soc;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  riscv_soc u_dut (.clk(clk), .rstn(rstn));

  always #5 clk = ~clk;

  localparam logic [6:0] T_LUI = 7'h37, T_IMM = 7'h13, T_OP = 7'h33, T_LOAD = 7'h03;
  localparam logic [6:0] T_STORE = 7'h23, T_BR = 7'h63, T_JAL = 7'h6F;

  typedef struct {
    string       name;
    bit          is_cyc;
    int          idx;
    logic [31:0] value;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          armed = 0;
  bit          done = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // ---- instruction encoders ----
  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, T_OP};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[11:5], rs2, rs1, f3, v[4:0], T_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], T_BR};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input logic [4:0] rd);
    logic [31:0] v = imm20;
    return {v[19:0], rd, T_LUI};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, T_JAL};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    return enc_i(imm, rs1, 3'd0, rd, T_IMM);
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask
  task automatic expect_reg(input string name, input int r, input logic [31:0] v);
    exp_t e;
    e.name = name; e.is_cyc = 0; e.idx = r; e.value = v;
    exp_q.push_back(e);
  endtask
  task automatic expect_cyc(input string name, input int n);
    exp_t e;
    e.name = name; e.is_cyc = 1; e.idx = 0; e.value = n;
    exp_q.push_back(e);
  endtask

  // Cycles since reset release; the monitor uses it to check pipeline timing.
  always @(posedge clk) begin
    if (rstn) cyc = 0;
    else      cyc++;
  end

  // Monitor: the DUT signals completion by x26=1; then the scoreboard drains.
  always @(negedge clk) begin
    if (armed && !rstn && u_dut.rf[26] == 32'd1) begin
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_cyc) check(e.name, cyc, e.value);
        else          check(e.name, u_dut.rf[e.idx], e.value);
      end
      armed = 0;
      done  = 1;
    end
  end

  // Preload the same image into ROM and RAM, run, optionally pulse reset
  // mid-run, and wait a bounded number of cycles for completion.
  task automatic run(input string name, input int budget, input int reset_at);
    @(negedge clk) rstn = 1'b1;
    foreach (prog[i]) begin
      u_dut.u_rom.mem[i]  = prog[i];
      u_dut.u_ram0.mem[i] = prog[i][7:0];
      u_dut.u_ram1.mem[i] = prog[i][15:8];
      u_dut.u_ram2.mem[i] = prog[i][23:16];
      u_dut.u_ram3.mem[i] = prog[i][31:24];
    end
    done = 0;
    @(negedge clk);
    @(negedge clk) begin rstn = 1'b0; armed = 1; end
    if (reset_at > 0) begin
      repeat (reset_at) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk) rstn = 1'b0;
    end
    for (int c = 0; c < budget && !done; c++) @(posedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: x26=0x%08h after %0d cycles, required 0x00000001",
               name, u_dut.rf[26], budget);
      armed = 0;
      exp_q.delete();
    end
    prog.delete();
  endtask

  task automatic build_isa_prog();
    emit(addi(3, 0, 1));
    emit(addi(1, 0, -1));
    emit(enc_i(28, 1, 3'd5, 2, T_IMM));      // srli x2,x1,28
    emit(addi(4, 0, 15));
    emit(enc_b(32, 4, 2, 3'd1));             // bne x2,x4,fail
    emit(addi(3, 0, 2));
    emit(enc_b(8, 0, 1, 3'd4));              // blt x1,x0,+8
    emit(enc_j(20, 0));                      // j fail
    emit(enc_b(16, 0, 1, 3'd6));             // bltu x1,x0,fail
    emit(addi(27, 0, 1));
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    emit(addi(26, 0, 1));                    // fail:
    emit(enc_j(0, 0));
  endtask

  initial begin
    // Forwarding: dependent addi back-to-back, zero stalls.
    emit(addi(1, 0, 5));
    emit(addi(2, 1, -7));
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    expect_reg("fwd_x1", 1, 32'd5);
    expect_reg("fwd_x2", 2, 32'hFFFF_FFFE);
    expect_cyc("fwd_cycles", 5);
    run("fwd", 200, 0);

    // x0 immutability, shifts, compares, not-taken branch.
    emit(addi(0, 0, 7));
    emit(enc_r(7'h00, 0, 0, 3'd0, 17));      // add x17,x0,x0
    emit(enc_u(32'h80000, 18));              // lui x18,0x80000
    emit(addi(19, 0, 33));
    emit(enc_r(7'h20, 19, 18, 3'd5, 20));    // sra x20,x18,x19
    emit(enc_i(12'h41F, 18, 3'd5, 21, T_IMM)); // srai x21,x18,31
    emit(enc_r(7'h00, 0, 18, 3'd2, 22));     // slt x22,x18,x0
    emit(enc_r(7'h00, 0, 18, 3'd3, 23));     // sltu x23,x18,x0
    emit(enc_r(7'h20, 19, 0, 3'd0, 24));     // sub x24,x0,x19
    emit(enc_b(8, 0, 0, 3'd1));              // bne x0,x0,+8 (not taken)
    emit(enc_i(-1, 18, 3'd4, 25, T_IMM));    // xori x25,x18,-1
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    expect_reg("x0_zero", 0, 32'd0);
    expect_reg("add_x0", 17, 32'd0);
    expect_reg("sra_33", 20, 32'hC000_0000);
    expect_reg("srai_31", 21, 32'hFFFF_FFFF);
    expect_reg("slt", 22, 32'd1);
    expect_reg("sltu", 23, 32'd0);
    expect_reg("sub", 24, 32'hFFFF_FFDF);
    expect_reg("xori", 25, 32'h7FFF_FFFF);
    expect_cyc("alu_cycles", 14);
    run("alu", 200, 0);

    // Byte-lane loads and stores, aliasing of upper address bits.
    emit(enc_u(2, 10));                      // lui x10,0x2
    emit(enc_u(32'h80FF8, 5));
    emit(addi(5, 5, -255));                  // x5 = 0x80FF7F01
    emit(enc_s(0, 5, 10, 3'd2));             // sw x5,0(x10)
    emit(enc_s(4, 0, 10, 3'd2));             // sw x0,4(x10)
    emit(enc_i(0, 10, 3'd1, 6, T_LOAD));     // lh x6,0(x10)
    emit(enc_i(2, 10, 3'd1, 7, T_LOAD));     // lh x7,2(x10)
    emit(enc_i(3, 10, 3'd4, 8, T_LOAD));     // lbu x8,3(x10)
    emit(enc_i(3, 10, 3'd0, 14, T_LOAD));    // lb x14,3(x10)
    emit(enc_i(2, 10, 3'd5, 15, T_LOAD));    // lhu x15,2(x10)
    emit(addi(13, 0, 32'h55));
    emit(enc_s(1, 13, 10, 3'd0));            // sb x13,1(x10)
    emit(enc_s(6, 13, 10, 3'd1));            // sh x13,6(x10)
    emit(enc_i(0, 10, 3'd2, 16, T_LOAD));    // lw x16,0(x10)
    emit(enc_i(4, 10, 3'd2, 4, T_LOAD));     // lw x4,4(x10)
    emit(enc_u(32'h102, 9));                 // lui x9,0x102 (aliases 0x2000)
    emit(enc_i(0, 9, 3'd2, 17, T_LOAD));     // lw x17,0(x9)
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    expect_reg("lh_lo", 6, 32'h0000_7F01);
    expect_reg("lh_hi", 7, 32'hFFFF_80FF);
    expect_reg("lbu_3", 8, 32'h0000_0080);
    expect_reg("lb_3", 14, 32'hFFFF_FF80);
    expect_reg("lhu_hi", 15, 32'h0000_80FF);
    expect_reg("sb_lane1", 16, 32'h80FF_5501);
    expect_reg("sh_upper", 4, 32'h0055_0000);
    expect_reg("alias_lw", 17, 32'h80FF_5501);
    expect_cyc("mem_cycles", 20);
    run("mem", 200, 0);

    // Load-use: exactly one bubble.
    emit(enc_u(2, 10));
    emit(addi(13, 0, 3));
    emit(enc_s(8, 13, 10, 3'd2));            // sw x13,8(x10)
    emit(enc_i(8, 10, 3'd2, 9, T_LOAD));     // lw x9,8(x10)
    emit(enc_r(7'h00, 9, 9, 3'd0, 11));      // add x11,x9,x9
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    expect_reg("lu_x9", 9, 32'd3);
    expect_reg("lu_x11", 11, 32'd6);
    expect_cyc("lu_cycles", 9);
    run("loaduse", 200, 0);

    // Taken branch and jal: two flushed slots each, link = pc+4.
    emit(enc_b(12, 0, 0, 3'd0));             // beq x0,x0,+12
    emit(addi(12, 0, 1));
    emit(addi(12, 0, 2));
    emit(enc_j(8, 1));                       // jal x1,+8
    emit(addi(12, 0, 3));
    emit(addi(26, 0, 1));
    emit(enc_j(0, 0));
    expect_reg("br_x12", 12, 32'd0);
    expect_reg("jal_link", 1, 32'd16);
    expect_cyc("br_cycles", 9);
    run("branch", 200, 0);

    // Asynchronous reset clears GPRs and PC before any clock edge.
    @(negedge clk) rstn = 1'b1;
    #1;
    check("reset_x1", u_dut.rf[1], 32'd0);
    check("reset_x26", u_dut.rf[26], 32'd0);
    check("reset_pc", u_dut.pc, 32'd0);

    // Self-checking image, then the same image with a mid-run reset.
    build_isa_prog();
    expect_reg("isa_pass", 27, 32'd1);
    expect_reg("isa_testnum", 3, 32'd2);
    run("isa", 25000, 0);

    build_isa_prog();
    expect_reg("isa_rst_pass", 27, 32'd1);
    expect_reg("isa_rst_testnum", 3, 32'd2);
    run("isa_rst", 25000, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
